// File: rtl/cnn_pkg.sv
// Shared CNN constants: FP32 field positions and the pooling FSM state encoding.
// Also provides the sign-magnitude ordering key used by the float max comparators.
package cnn_pkg;

    localparam int          FP_SIGN_BIT = 31;
    localparam logic [31:0] FP_ZERO     = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Maps a sign-magnitude word onto an unsigned key with the same order:
    // positives move above every negative, and negatives invert so smaller magnitude ranks higher.
    function automatic logic [31:0] fp_order_key(input logic [31:0] x);
        return x[FP_SIGN_BIT] ? ~x : {1'b1, x[FP_SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/float_max2.sv
// Combinational two-input FP32 max using sign-magnitude ordering; on a tie the
// first input (a) is kept, and +0/-0 compare equal. NaN/Inf are ordinary bit patterns here.
module float_max2
    import cnn_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic both_zero;
    logic b_greater;

    // +0 and -0 have different keys, so zero magnitudes are forced to a tie first.
    assign both_zero = (a[FP_SIGN_BIT-1:0] == '0) && (b[FP_SIGN_BIT-1:0] == '0);
    assign b_greater = !both_zero && (fp_order_key(b) > fp_order_key(a));
    assign y         = b_greater ? b : a;

endmodule

// File: rtl/max_pool_relu_layer.sv
// 2x2 stride-2 max pooling over an HxW FP32 feature map, one output per clock.
// Optional ReLU on each written output when MAX_POOL_RELU_EN is defined.
module max_pool_relu_layer
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int H          = 28,
    parameter int W          = 28
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [H*W*DATA_WIDTH-1:0]                featureMap,
    output logic [(H/2)*(W/2)*DATA_WIDTH-1:0]        pooled,
    output logic                                     busy,
    output logic                                     done
);

    localparam int PH    = H / 2;
    localparam int PW    = W / 2;
    localparam int NP    = PH * PW;
    localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;
    localparam int ROW_W = (PH > 1) ? $clog2(PH) : 1;
    localparam int COL_W = (PW > 1) ? $clog2(PW) : 1;

    state_t                  state;
    state_t                  state_next;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        col;
    logic [IDX_W-1:0]        idx;
    logic                    last;

    logic [DATA_WIDTH-1:0]   win_tl [NP];
    logic [DATA_WIDTH-1:0]   win_tr [NP];
    logic [DATA_WIDTH-1:0]   win_bl [NP];
    logic [DATA_WIDTH-1:0]   win_br [NP];
    logic [DATA_WIDTH-1:0]   max_top;
    logic [DATA_WIDTH-1:0]   max_bot;
    logic [DATA_WIDTH-1:0]   pool_max;
    logic [DATA_WIDTH-1:0]   result;
    logic [DATA_WIDTH-1:0]   pooled_words [NP];

    // Static wiring of every window's four taps; odd trailing rows/columns are never referenced.
    for (genvar k = 0; k < NP; k++) begin : g_win
        localparam int R = 2 * (k / PW);
        localparam int C = 2 * (k % PW);
        assign win_tl[k] = featureMap[(R*W + C)*DATA_WIDTH       +: DATA_WIDTH];
        assign win_tr[k] = featureMap[(R*W + C + 1)*DATA_WIDTH   +: DATA_WIDTH];
        assign win_bl[k] = featureMap[((R+1)*W + C)*DATA_WIDTH   +: DATA_WIDTH];
        assign win_br[k] = featureMap[((R+1)*W + C+1)*DATA_WIDTH +: DATA_WIDTH];
        assign pooled[k*DATA_WIDTH +: DATA_WIDTH] = pooled_words[k];
    end

    // Left subtree always holds the earlier elements, so ties resolve to window order.
    float_max2 u_max_top (.a(win_tl[idx]), .b(win_tr[idx]), .y(max_top));
    float_max2 u_max_bot (.a(win_bl[idx]), .b(win_br[idx]), .y(max_bot));
    float_max2 u_max_out (.a(max_top),     .b(max_bot),     .y(pool_max));

`ifdef MAX_POOL_RELU_EN
    assign result = pool_max[FP_SIGN_BIT] ? FP_ZERO : pool_max;
`else
    assign result = pool_max;
`endif

    assign last = (row == ROW_W'(PH - 1)) && (col == COL_W'(PW - 1));
    assign busy = (state != IDLE);

    // NOTE: every register below uses non-blocking assignment so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: pooled_words is a flop array, not a RAM, so it takes the async reset and a bulk clear on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row          <= '0;
            col          <= '0;
            idx          <= '0;
            done         <= 1'b0;
            pooled_words <= '{default: '0};
        end else begin
            done <= (state == RUN) && last;
            case (state)
                IDLE: begin
                    if (start) begin
                        row          <= '0;
                        col          <= '0;
                        idx          <= '0;
                        pooled_words <= '{default: '0};
                    end
                end
                RUN: begin
                    pooled_words[idx] <= result;
                    if (last) begin
                        row <= '0;
                        col <= '0;
                        idx <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        if (col == COL_W'(PW - 1)) begin
                            col <= '0;
                            row <= row + ROW_W'(1);
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max_pool_relu_layer.sv
// Scoreboard bench for max_pool_relu_layer: a 4x4 and a 5x5 instance, directed maps,
// expected pooled words and done cycles queued at launch and checked by a done monitor.
module tb_max_pool_relu_layer;

    localparam int DW = 32;

`ifdef MAX_POOL_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start4 = 1'b0;
    logic                 start5 = 1'b0;
    logic [4*4*DW-1:0]    fm4 = '0;
    logic [5*5*DW-1:0]    fm5 = '0;
    logic [4*DW-1:0]      pooled4;
    logic [4*DW-1:0]      pooled5;
    logic                 busy4, busy5, done4, done5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [4*DW-1:0] words;
        int              done_cyc;
    } exp_t;

    exp_t sb4[$];
    exp_t sb5[$];

    max_pool_relu_layer #(.DATA_WIDTH(DW), .H(4), .W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .featureMap(fm4),
        .pooled(pooled4), .busy(busy4), .done(done4)
    );

    max_pool_relu_layer #(.DATA_WIDTH(DW), .H(5), .W(5)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .featureMap(fm5),
        .pooled(pooled5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pass(input string tag, input exp_t e, input logic [4*DW-1:0] act);
        for (int k = 0; k < 4; k++)
            check($sformatf("%s word%0d", tag, k), act[k*DW +: DW], e.words[k*DW +: DW]);
        check({tag, " done cycle"}, cyc, e.done_cyc);
    endtask

    // Positive integer to FP32 bit pattern (exact for small values).
    function automatic logic [31:0] fp_of(input int n);
        int          e;
        logic [31:0] m;
        e = 0;
        for (int i = 0; i < 30; i++) if (n >= (1 << i)) e = i;
        m = 32'(n - (1 << e)) << (23 - e);
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done4) begin
            if (sb4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4 done: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb4.pop_front();
                check_pass("dut4", e, pooled4);
            end
        end
        if (done5) begin
            if (sb5.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut5 done: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                e = sb5.pop_front();
                check_pass("dut5", e, pooled5);
            end
        end
    end

    task automatic launch(input bit which, output int c0);
        @(negedge clk);
        if (which) start5 = 1'b1;
        else       start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start5 = 1'b0;
        c0 = cyc;
    endtask

    task automatic push(input bit which, input logic [4*DW-1:0] words, input int done_cyc);
        exp_t e;
        e.words    = words;
        e.done_cyc = done_cyc;
        if (which) sb5.push_back(e);
        else       sb4.push_back(e);
    endtask

    task automatic wait_done(input bit which);
        int n = 0;
        while (!(which ? done5 : done4) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++; errors++;
            $display("FAIL wait_done dut%0d: no done within 40 cycles, expected a pulse", which ? 5 : 4);
        end
        @(negedge clk);
    endtask

    task automatic load_seq4();
        for (int k = 0; k < 16; k++) fm4[k*DW +: DW] = fp_of(k + 1);
    endtask

    localparam logic [4*DW-1:0] EXP_SEQ4 = {32'h41800000, 32'h41600000, 32'h41000000, 32'h40C00000};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          c0;
        logic [31:0] mixed [16];

        // Reset state, sampled while reset is asserted.
        #2;
        check("reset busy4", {31'b0, busy4}, 32'd0);
        check("reset done4", {31'b0, done4}, 32'd0);
        check("reset pooled4 any", {31'b0, |pooled4}, 32'd0);
        check("reset busy5", {31'b0, busy5}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Ascending 1..16 on 4x4 and 1..25 on 5x5.
        load_seq4();
        for (int k = 0; k < 25; k++) fm5[k*DW +: DW] = fp_of(k + 1);
        launch(0, c0);
        check("busy4 in RUN", {31'b0, busy4}, 32'd1);
        push(0, EXP_SEQ4, c0 + 4);
        wait_done(0);
        check("busy4 after DONE", {31'b0, busy4}, 32'd0);
        repeat (3) @(negedge clk);
        check("pooled4 held word0", pooled4[31:0], 32'h40C00000);

        launch(1, c0);
        push(1, {32'h41980000, 32'h41880000, 32'h41100000, 32'h40E00000}, c0 + 4);
        wait_done(1);

        // Negatives, signed zeros, NaN/Inf, and positive-beats-negative windows.
        mixed = '{32'hC0400000, 32'hBF800000, 32'h80000000, 32'h00000000,
                  32'hC0000000, 32'hC0800000, 32'hBF800000, 32'hC0000000,
                  32'h7F800000, 32'h7FC00000, 32'hC1800000, 32'h40000000,
                  32'h3F800000, 32'hFF800000, 32'hBF000000, 32'h00000000};
        for (int k = 0; k < 16; k++) fm4[k*DW +: DW] = mixed[k];
        launch(0, c0);
        push(0, {32'h40000000, 32'h7FC00000,
                 RELU_ON ? 32'h00000000 : 32'h80000000,
                 RELU_ON ? 32'h00000000 : 32'hBF800000}, c0 + 4);
        wait_done(0);

        // Descending map with start re-pulsed on the second RUN cycle.
        for (int k = 0; k < 16; k++) fm4[k*DW +: DW] = fp_of(16 - k);
        launch(0, c0);
        push(0, {32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000}, c0 + 4);
        @(negedge clk);
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(0);

        // Reset on the second RUN cycle aborts the pass; nothing is queued for it.
        load_seq4();
        launch(0, c0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort pooled4 any", {31'b0, |pooled4}, 32'd0);
        check("abort busy4", {31'b0, busy4}, 32'd0);
        check("abort done4", {31'b0, done4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("idle after abort busy4", {31'b0, busy4}, 32'd0);
        launch(0, c0);
        push(0, EXP_SEQ4, c0 + 4);
        wait_done(0);

        repeat (2) @(negedge clk);
        check("sb4 drained", 32'(sb4.size()), 32'd0);
        check("sb5 drained", 32'(sb5.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/max_pool_relu_layer.md
MAX_POOL_RELU_LAYER -- requirements
Module: max_pool_relu_layer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width in IEEE-754 single-precision format.
REQ-002 SHALL have parameter H, default 28, meaning input feature-map height, which is the conv output height.
REQ-003 SHALL have parameter W, default 28, meaning input feature-map width.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that launches pooling of the current featureMap.
REQ-007 SHALL have port featureMap, input, H*W*DATA_WIDTH, row-major map with element (r,c) at bits [(r*W+c)*DATA_WIDTH +: DATA_WIDTH] and MSB-first indexing.
REQ-008 SHALL have port pooled, output reg, (H/2)*(W/2)*DATA_WIDTH, row-major pooled map using the same indexing.
REQ-009 SHALL have port busy, output, 1, high while a pooling pass is in progress.
REQ-010 SHALL have port done, output reg, 1, one-cycle pulse when pooled is complete.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE, with reset state IDLE.
REQ-012 SHALL transition IDLE->RUN when start=1, clearing pooled to 0 and row and col counters to 0.
REQ-013 In RUN, SHALL compute one output per clock: pooled[pr][pc] = max of elements (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-014 SHALL advance col each cycle; at col=W/2-1, col SHALL wrap to 0 and row SHALL increment.
REQ-015 SHALL transition RUN->DONE after the write of the last element (H/2-1, W/2-1); DONE->IDLE SHALL occur unconditionally the next cycle.
REQ-016 SHALL assert done for exactly the DONE cycle; the total from the start cycle to the done cycle SHALL be (H/2)*(W/2)+1 clocks.
REQ-017 SHALL assert busy in RUN and DONE.
REQ-018 SHALL ignore start while busy, so that no restart and no counter disturbance occurs.
REQ-019 SHALL order floats by sign-magnitude: a positive word beats a negative word; among positives the larger magnitude wins; among negatives the smaller magnitude wins.
REQ-020 SHALL treat +0 and -0 as equal; on a tie the earlier element in the window order of REQ-013 SHALL be kept.
REQ-021 SHALL pass NaN/Inf bit patterns through the sign-magnitude rule without special handling.
REQ-022 For odd H or W, SHALL drop the last row or column (floor division) with no error.
REQ-023 SHALL hold featureMap stable from start through done; this is the caller's responsibility and is not checked.
REQ-024 SHALL hold pooled stable between passes; pooled SHALL change only in RUN or on the IDLE->RUN clear.

Reset
REQ-025 On reset=1, state SHALL be IDLE, row=col=0, pooled=0, done=0, and busy=0, immediately and asynchronously.
REQ-026 Reset asserted mid-RUN SHALL abort the pass with no done pulse; a new start SHALL be required after release.

Configuration
REQ-027 With macro MAX_POOL_RELU_EN defined, each written output SHALL be ReLU'd: a result with sign bit 1 SHALL be written as 32'h00000000, and this SHALL add no latency.
REQ-028 Without MAX_POOL_RELU_EN, raw max values, including negatives and -0, SHALL be written.

Structure
REQ-029 Shared package cnn_pkg SHALL hold the FP32 constants FP_SIGN_BIT=31, FP_ZERO=32'h0, and the FSM state encodings.
REQ-030 Sub-module float_max2 SHALL be a combinational two-input FP32 max implementing REQ-019 and REQ-020; it SHALL be instantiated three times as a tree.

Verification
REQ-031 Scenario: H=W=4, map values 1.0..16.0 row-major, start -> pooled = {6.0, 8.0, 14.0, 16.0}, done on cycle 5 after start.
REQ-032 Scenario: window {-3.0, -1.0, -2.0, -4.0} -> output -1.0 (32'hBF800000) without MAX_POOL_RELU_EN, and 32'h00000000 with it.
REQ-033 Scenario: window {-0.0, +0.0, -1.0, -2.0} -> 32'h80000000 without ReLU, because the tie keeps the first element.
REQ-034 Scenario: H=W=5, values 1..25 -> 2x2 output {7, 9, 17, 19}; row 4 and column 4 are ignored.
REQ-035 Scenario: start re-pulsed on cycle 2 of RUN -> done still occurs at the original cycle and results are unchanged.
REQ-036 Scenario: reset asserted on cycle 2 of RUN -> pooled=0, busy=0, and no done; then start -> a correct full pass.
